edge_prefetch: RTL

Edge-list prefetcher sitting directly upstream of the edge scheduler in the GNN aggregation path. On a `start` command it streams a contiguous range of 24-bit edge words out of the edge-table RAM into an 8-entry first-word-fall-through FIFO. The FIFO's `edge_empty`, inverted, is the scheduler's task-pending input. The scheduler consumes the head edge with `edge_pop`. Each edge word is packed as src node index in bits [23:12] and dst node index in bits [11:0].

---
 rtl/edge_pkg.sv | 24 ++
 rtl/edge_fifo.sv | 57 +++++
 rtl/edge_prefetch.sv | 111 +++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
// Shared constants, field positions and FSM encoding for the edge prefetcher.
// Optional build macro used by edge_prefetch: EDGE_SELF_LOOP_DROP_EN.
package edge_pkg;

    localparam int EDGE_W     = 24;
    localparam int ADDR_W     = 5;
    localparam int FIFO_DEPTH = 8;

    localparam int SRC_MSB = 23;
    localparam int SRC_LSB = 12;
    localparam int DST_MSB = 11;
    localparam int DST_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT
    } state_e;

    function automatic logic is_self_loop(input logic [EDGE_W-1:0] word);
        return word[SRC_MSB:SRC_LSB] == word[DST_MSB:DST_LSB];
    endfunction

endpackage

// File: rtl/edge_fifo.sv
// First-word-fall-through FIFO: the head entry is always visible on data_out,
// empty and level are registered.
module edge_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             empty_q;
    logic             pop_ok;

    // A pop against an empty FIFO is ignored rather than underflowing.
    assign pop_ok  = pop && !empty_q;
    assign level_d = level_q + LVL_W'(push) - LVL_W'(pop_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= data_in;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
            empty_q <= (level_d == '0);
        end
    end

    assign data_out = mem_q[rd_ptr_q];
    assign empty    = empty_q;
    assign level    = level_q;

endmodule

// File: rtl/edge_prefetch.sv
// Streams a contiguous edge-table range into the prefetch FIFO with credit-based issue.
// Define EDGE_SELF_LOOP_DROP_EN to discard returned edges whose src equals dst.
module edge_prefetch #(
    parameter int EDGE_W     = edge_pkg::EDGE_W,
    parameter int ADDR_W     = edge_pkg::ADDR_W,
    parameter int FIFO_DEPTH = edge_pkg::FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [ADDR_W:0]               num_edges,
    output logic                          busy,
    output logic                          done,
    output logic                          ram_en,
    output logic [ADDR_W-1:0]             ram_addr,
    input  logic [EDGE_W-1:0]             ram_rdata,
    output logic [EDGE_W-1:0]             edge_data,
    output logic                          edge_empty,
    input  logic                          edge_pop,
    output logic [$clog2(FIFO_DEPTH):0]   edge_level
);
    import edge_pkg::*;

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     remaining_q;
    logic                rvalid_q;
    logic                busy_q;
    logic                done_q;
    logic                issue;
    logic                push;
    logic [LVL_W-1:0]    level;

    // The single outstanding read is counted as occupied so a push can never overflow.
    assign issue = (state_q == FETCH) && (remaining_q != '0) &&
                   ((level + LVL_W'(rvalid_q)) < LVL_W'(FIFO_DEPTH));

`ifdef EDGE_SELF_LOOP_DROP_EN
    assign push = rvalid_q && !is_self_loop(ram_rdata);
`else
    assign push = rvalid_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            rvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rvalid_q <= issue;
            done_q   <= 1'b0;
            case (state_q)
                FETCH: begin
                    if (issue) begin
                        addr_q      <= addr_q + 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                        // done lands on the cycle this last read returns
                        if (remaining_q == (ADDR_W+1)'(1)) begin
                            state_q <= WAIT;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    // WAIT lasts one cycle; busy is already low, so a new start is taken here too
                    if (state_q == WAIT && rvalid_q) begin
                        state_q <= IDLE;
                    end
                    if (start) begin
                        if (num_edges == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= FETCH;
                            addr_q      <= base_addr;
                            remaining_q <= num_edges;
                            busy_q      <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    edge_fifo #(
        .WIDTH (EDGE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (edge_pop),
        .data_in  (ram_rdata),
        .data_out (edge_data),
        .empty    (edge_empty),
        .level    (level)
    );

    assign ram_en     = issue;
    assign ram_addr   = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign edge_level = level;

endmodule
